// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic ops and adds, radix-2 iterative unsigned
// multiply and divide, with a start/busy/done handshake for stalling EX.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           Function,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Out,
    output logic                 O,
    output logic                 N,
    output logic                 Z,
    output logic                 err
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_MEM = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            is_div_q, is_div_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   out_q, out_d;
    logic            o_q, o_d;
    logic            n_q, n_d;
    logic            z_q, z_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    // Single-cycle result, computed straight from the live inputs on the accept edge
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] diff_w;
    logic             add_ovf;
    logic             sub_ovf;
    logic [W2-1:0]    quick_out;
    logic             quick_o;
    logic             quick_err;

    always_comb begin
        sum_w     = A + B;
        diff_w    = A - B;
        add_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
        sub_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_w[WIDTH-1] != A[WIDTH-1]);
        quick_out = '0;
        quick_o   = 1'b0;
        quick_err = 1'b0;
        case (Function)
            OP_ADD: begin
                quick_out = {{WIDTH{sum_w[WIDTH-1]}}, sum_w};
                quick_o   = add_ovf;
            end
            OP_SUB: begin
                quick_out = {{WIDTH{diff_w[WIDTH-1]}}, diff_w};
                quick_o   = sub_ovf;
            end
            OP_AND: quick_out = {{WIDTH{1'b0}}, A & B};
            OP_OR:  quick_out = {{WIDTH{1'b0}}, A | B};
            OP_MEM: quick_out = {{WIDTH{1'b0}}, sum_w};
            OP_MUL, OP_DIV: quick_err = 1'b0;
            default: quick_err = 1'b1;
        endcase
    end

    // One iteration step. Multiply keeps {partial product, multiplier} and shifts
    // right; divide keeps {remainder, dividend/quotient} and shifts left.
    logic [WIDTH:0]   mul_add;
    logic [W2-1:0]    mul_next;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    logic [WIDTH-1:0] rem_new;
    logic [W2-1:0]    div_next;
    logic [W2-1:0]    step_next;

    always_comb begin
        mul_add   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_add, acc_q[WIDTH-1:1]};
        rem_sh    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge    = rem_sh >= {1'b0, b_q};
        rem_diff  = rem_sh[WIDTH-1:0] - b_q;
        rem_new   = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
        div_next  = {rem_new, acc_q[WIDTH-2:0], rem_ge};
        step_next = is_div_q ? div_next : mul_next;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        out_d    = out_q;
        o_d      = o_q;
        n_d      = n_q;
        z_d      = z_q;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = A;
                    b_d = B;
                    if (Function == OP_MUL) begin
                        state_d  = RUN;
                        count_d  = '0;
                        is_div_d = 1'b0;
                        acc_d    = {{WIDTH{1'b0}}, B};
                    end else if (Function == OP_DIV) begin
                        state_d  = RUN;
                        count_d  = '0;
                        is_div_d = 1'b1;
                        acc_d    = {{WIDTH{1'b0}}, A};
                    end else begin
                        out_d  = quick_out;
                        o_d    = quick_o;
                        n_d    = quick_out[W2-1];
                        z_d    = (quick_out == '0);
                        err_d  = quick_err;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_d   = step_next;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    out_d   = step_next;
                    o_d     = is_div_q ? (b_q == '0) : (step_next[W2-1:WIDTH] != '0);
                    n_d     = step_next[W2-1];
                    z_d     = (step_next == '0);
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            o_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            o_q      <= o_d;
            n_q      <= n_d;
            z_q      <= z_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign Out  = out_q;
    assign O    = o_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign err  = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [3:0]     func;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] out;
    logic           o_flag;
    logic           n_flag;
    logic           z_flag;
    logic           err;

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] exp_out;
    logic           exp_o;
    logic           exp_err;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .Function (func),
        .A        (a),
        .B        (b),
        .busy     (busy),
        .done     (done),
        .Out      (out),
        .O        (o_flag),
        .N        (n_flag),
        .Z        (z_flag),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference result as {err, O, Out}, computed with plain integer arithmetic
    function automatic logic [2*W+1:0] model(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        int             sx;
        int             sy;
        int             r;
        logic [W-1:0]   t;
        logic [2*W-1:0] p;
        logic [2*W-1:0] res;
        logic           ov;
        logic           er;
        sx  = $signed(x);
        sy  = $signed(y);
        res = '0;
        ov  = 1'b0;
        er  = 1'b0;
        case (f)
            4'b0000: begin
                r   = sx + sy;
                t   = x + y;
                res = {{W{t[W-1]}}, t};
                ov  = (r > 32767) || (r < -32768);
            end
            4'b0001: begin
                r   = sx - sy;
                t   = x - y;
                res = {{W{t[W-1]}}, t};
                ov  = (r > 32767) || (r < -32768);
            end
            4'b1000: res = {16'h0000, x & y};
            4'b1001: res = {16'h0000, x | y};
            4'b1100: begin
                t   = x + y;
                res = {16'h0000, t};
            end
            4'b0100: begin
                p   = 32'(x) * 32'(y);
                res = p;
                ov  = p > 32'h0000FFFF;
            end
            4'b0101: begin
                if (y == 0) begin
                    res = {x, 16'hFFFF};
                    ov  = 1'b1;
                end else begin
                    res = {16'(x % y), 16'(x / y)};
                end
            end
            default: er = 1'b1;
        endcase
        return {er, ov, res};
    endfunction

    task automatic checkOutput(input string tag, input logic [2*W-1:0] observed, input logic [2*W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one operation at the current (post-edge) time and checks the whole
    // handshake plus result; optionally spams start while busy and checks hold afterwards.
    task automatic applyStimulus(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit junk_while_busy, input bit idle_after);
        logic [2*W+1:0] m;
        m       = model(f, x, y);
        exp_err = m[2*W+1];
        exp_o   = m[2*W];
        exp_out = m[2*W-1:0];
        start = 1'b1;
        func  = f;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        func  = 4'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        if (f == 4'b0100 || f == 4'b0101) begin
            for (int i = 0; i < W; i++) begin
                checkOutput("busy_high", 32'(busy), 32'd1);
                checkOutput("done_low_while_busy", 32'(done), 32'd0);
                if (junk_while_busy) begin
                    start = 1'b1;
                    func  = 4'($urandom);
                    a     = W'($urandom);
                    b     = W'($urandom);
                end
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_low", 32'(busy), 32'd0);
        checkOutput("out", out, exp_out);
        checkOutput("o_flag", 32'(o_flag), 32'(exp_o));
        checkOutput("n_flag", 32'(n_flag), 32'(exp_out[2*W-1]));
        checkOutput("z_flag", 32'(z_flag), 32'(exp_out == '0));
        checkOutput("err", 32'(err), 32'(exp_err));
        if (idle_after) begin
            @(posedge clk);
            #1;
            checkOutput("done_single_cycle", 32'(done), 32'd0);
            checkOutput("out_hold", out, exp_out);
            checkOutput("err_hold", 32'(err), 32'(exp_err));
        end
    endtask

    initial begin
        logic [3:0] codes [8];
        int         done_seen;
        logic [3:0] f;
        logic [W-1:0] x;
        logic [W-1:0] y;

        codes[0] = 4'b0000;
        codes[1] = 4'b0001;
        codes[2] = 4'b1000;
        codes[3] = 4'b1001;
        codes[4] = 4'b1100;
        codes[5] = 4'b0100;
        codes[6] = 4'b0101;
        codes[7] = 4'b0011;

        rst_n = 1'b0;
        start = 1'b0;
        func  = 4'b0000;
        a     = '0;
        b     = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_outputs", {busy, done, o_flag, n_flag, z_flag, err, out[25:0]}, 32'd0);
        checkOutput("reset_out", out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed arithmetic and logic cases");
        applyStimulus(4'b0000, 16'hFF00, 16'hFFFF, 1'b0, 1'b1);
        checkOutput("add_const", out, 32'hFFFFFEFF);
        applyStimulus(4'b0001, 16'hFF00, 16'hFFFF, 1'b0, 1'b0);
        checkOutput("sub_const", out, 32'hFFFFFF01);
        applyStimulus(4'b0000, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        checkOutput("add_ovf_const", {out[31:1], o_flag}, {31'h7FFFC000, 1'b1});
        applyStimulus(4'b1000, 16'hFFFF, 16'hB0B0, 1'b0, 1'b0);
        checkOutput("and_const", out, 32'h0000B0B0);
        applyStimulus(4'b1001, 16'hFFFF, 16'hB0B0, 1'b0, 1'b0);
        applyStimulus(4'b1100, 16'h0000, 16'h0008, 1'b0, 1'b1);

        $display("[TB] directed multiply and divide");
        applyStimulus(4'b0100, 16'hFFFF, 16'hB0B0, 1'b1, 1'b0);
        checkOutput("mul_const", out, 32'hB0AF4F50);
        applyStimulus(4'b0101, 16'hFFFF, 16'hB0B0, 1'b0, 1'b1);
        checkOutput("div_const", out, 32'h4F4F0001);
        applyStimulus(4'b0101, 16'h1234, 16'h0000, 1'b1, 1'b1);
        checkOutput("div0_const", out, 32'h1234FFFF);

        $display("[TB] illegal code then add");
        applyStimulus(4'b0011, 16'hABCD, 16'h1234, 1'b0, 1'b0);
        applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b0, 1'b1);

        $display("[TB] reset during multiply");
        start = 1'b1;
        func  = 4'b0100;
        a     = 16'h1234;
        b     = 16'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("busy_before_abort", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_flags", {26'd0, busy, done, o_flag, n_flag, z_flag, err}, 32'd0);
        checkOutput("abort_out", out, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        checkOutput("no_done_after_abort", 32'(done_seen), 32'd0);
        applyStimulus(4'b0100, 16'h0003, 16'h0005, 1'b0, 1'b1);
        checkOutput("mul_small_const", out, 32'h0000000F);

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            f = codes[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) f = 4'($urandom);
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 7) == 0) y = '0;
            if ($urandom_range(0, 5) == 0) x = 16'h7FFF;
            applyStimulus(f, x, y, 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle ALU, the successor to the single-cycle 16-bit ALU in the pipeline datapath EX stage. It supports add, sub, and, or, memory-address add, and unsigned multiply and divide. Multiply and divide run iteratively at radix-2, one bit per clock. A start/busy/done handshake lets the pipeline control logic stall EX while a long operation completes.

Parameters:
WIDTH, 16, operand width in bits; legal values are WIDTH >= 4. Out is 2*WIDTH bits wide.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  request to begin an operation; sampled only while busy=0
Function  in  4  operation code (see Behaviour)
A  in  WIDTH  operand A
B  in  WIDTH  operand B
busy  out  1  high while a multiply or divide is iterating
done  out  1  one-cycle pulse when Out and the flags are updated
Out  out  2*WIDTH  result register
O  out  1  overflow / exception flag
N  out  1  negative flag, equal to Out[2*WIDTH-1]
Z  out  1  zero flag, Out == 0
err  out  1  high with done when the Function code was illegal

Behaviour:
- Reset (clk and reset already decided):
  - One clock, clk; reset is asynchronous and active-low, rst_n.
  - Asserting rst_n=0 immediately forces busy, done, Out, O, N, Z and err to 0.
  - The iteration counter and operand registers are cleared.
  - A reset during a multiply or divide aborts it; no done pulse is produced.
- Accept rule:
  - An operation is accepted on a rising edge where start=1 and busy=0.
  - A, B and Function are captured on that edge.
  - Later changes to A, B or Function do not affect the operation in flight.
  - start while busy=1 is ignored; it is neither queued nor flagged.
- Function codes:
  - 0000 ADD: W-bit two's-complement A+B, wraps, sign-extended to 2W. O = signed overflow.
  - 0001 SUB: W-bit A-B, wraps, sign-extended to 2W. O = signed overflow.
  - 1000 AND: zero-extended A&B. O=0.
  - 1001 OR: zero-extended A|B. O=0.
  - 1100 MEM address: zero-extended (A+B) mod 2^W. O=0.
  - 0100 MUL: unsigned full 2W-bit product. O=1 iff the upper W bits are nonzero.
  - 0101 DIV: unsigned. Out[W-1:0] = quotient, Out[2W-1:W] = remainder, O=0.
  - Divide by zero (B=0): quotient = all ones, remainder = A, O=1.
  - Any other code: Out=0, O=0, err=1.
- Latency:
  - All codes except MUL and DIV (start in cycle c): Out, flags, err and done=1 appear in cycle c+1. busy stays 0.
  - MUL and DIV (start in cycle c): busy=1 in cycles c+1 .. c+W, one shift-add or shift-subtract step per edge.
  - MUL/DIV results: in cycle c+W+1, busy=0, done=1, and Out and flags are updated.
  - A new start may be accepted in the same cycle that done is high.
- State machine: IDLE -> (accept MUL/DIV) -> RUN(count 0..W-1) -> IDLE.
  - The done pulse is registered on the last RUN edge.
  - A single-cycle op stays in IDLE and pulses done.
- Flags and hold:
  - Z and N are always derived from the full 2W-bit Out.
  - err clears on the next done.
  - Out, O, N, Z and err hold their values between done pulses.
  - done is never high for two consecutive cycles from a single accept.

Test Plan:
All scenarios use WIDTH=16.
1. ADD, A=FF00, B=FFFF -> next cycle: Out=FFFFFEFF, N=1, Z=0, O=0, done=1, busy=0. SUB with the same operands -> Out=FFFFFF01, N=1. ADD 7FFF+0001 -> Out=FFFF8000, O=1.
2. AND, A=FFFF, B=B0B0 -> Out=0000B0B0. OR with the same operands -> Out=0000FFFF. All flags 0. MEM, A=0000, B=0008 -> Out=00000008.
3. MUL, A=FFFF, B=B0B0 -> busy=1 for 16 cycles, then done=1 with Out=B0AF4F50, O=1, N=1. start pulses with new operands while busy -> no effect on the result.
4. DIV, A=FFFF, B=B0B0 -> done after 16 busy cycles, Out=4F4F0001, O=0. DIV, A=1234, B=0000 -> Out=1234FFFF, O=1.
5. Function=0011 -> next cycle: done=1, err=1, Out=0, Z=1. A following ADD, 0000+0000 -> err=0, Z=1.
6. Start MUL, then pull rst_n low at busy cycle 7 -> all outputs are 0 immediately and no done follows. After reset is released, MUL 0003*0005 -> Out=0000000F.
